// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter: register/data widths and the
// buffered write request carried through the long-latency result FIFO.
package regfile_write_arbiter_pkg;

    localparam int REG_W    = 3;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 1 << REG_W;

    typedef struct packed {
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // One-hot register mask, all-zero when the event is not happening.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_W-1:0] idx,
                                                     input logic            en);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (en) begin
            m[idx] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Signal bundle between the pipeline (writeback, long-latency unit, decode) and
// the register-file write arbiter.
interface regfile_write_arbiter_if;
    import regfile_write_arbiter_pkg::*;

    logic                wb_write;
    logic [REG_W-1:0]    wb_reg;
    logic [DATA_W-1:0]   wb_data;
    logic                wb_stall;

    logic                mu_valid;
    logic                mu_ready;
    logic [REG_W-1:0]    mu_reg;
    logic [DATA_W-1:0]   mu_data;
    logic                mu_issue;
    logic [REG_W-1:0]    mu_issue_reg;

    logic [REG_W-1:0]    dec_ra;
    logic [REG_W-1:0]    dec_rb;
    logic [REG_W-1:0]    dec_rd;
    logic                hazard_stall;
    logic [NUM_REGS-1:0] pending;

    logic                rf_write;
    logic [REG_W-1:0]    rf_reg;
    logic [DATA_W-1:0]   rf_data;

    modport slave (
        input  wb_write, wb_reg, wb_data,
        input  mu_valid, mu_reg, mu_data, mu_issue, mu_issue_reg,
        input  dec_ra, dec_rb, dec_rd,
        output wb_stall, mu_ready, hazard_stall, pending,
        output rf_write, rf_reg, rf_data
    );

    modport master (
        output wb_write, wb_reg, wb_data,
        output mu_valid, mu_reg, mu_data, mu_issue, mu_issue_reg,
        output dec_ra, dec_rb, dec_rd,
        input  wb_stall, mu_ready, hazard_stall, pending,
        input  rf_write, rf_reg, rf_data
    );

endinterface

// File: rtl/regfile_write_arbiter_wb_result_fifo.sv
// Synchronous FIFO of pending long-latency register writes; FIFO_DEPTH must be a
// power of two so the pointers wrap naturally.
module wb_result_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  wb_req_t push_req,
    input  logic    pop,
    output wb_req_t head_req,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_req_t          mem_p1 [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_req = mem_p1[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ---- storage stage: data path is not reset ----
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_p1[wr_ptr] <= push_req;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: writeback has priority, long-latency results
// drain from a FIFO, with a starvation override. Optional WBARB_BYPASS_EN macro.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);

    localparam int                STARVE_W   = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    wb_req_t             mu_req;
    wb_req_t             head_req;
    logic                full;
    logic                empty;
    logic                force_head;
    logic                wb_grant;
    logic                head_grant;
    logic                byp_grant;
    logic                push;
    logic [STARVE_W-1:0] starve_cnt;
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    assign mu_req.dst  = bus.mu_reg;
    assign mu_req.data = bus.mu_data;

    // All grants are qualified by reset so the outputs stay quiet while held.
    assign force_head = (starve_cnt == STARVE_LIM) && !empty;
    assign wb_grant   = reset && bus.wb_write && !force_head;
    assign head_grant = reset && !empty && !wb_grant;

`ifdef WBARB_BYPASS_EN
    assign byp_grant  = reset && bus.mu_valid && empty && !bus.wb_write;
`else
    assign byp_grant  = 1'b0;
`endif

    assign bus.mu_ready = reset && !full;
    assign bus.wb_stall = reset && bus.wb_write && force_head;
    assign push         = bus.mu_valid && bus.mu_ready && !byp_grant;

    wb_result_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_req (mu_req),
        .pop      (head_grant),
        .head_req (head_req),
        .full     (full),
        .empty    (empty)
    );

    always_comb begin
        bus.rf_write = 1'b0;
        bus.rf_reg   = head_req.dst;
        bus.rf_data  = head_req.data;
        if (wb_grant) begin
            bus.rf_write = 1'b1;
            bus.rf_reg   = bus.wb_reg;
            bus.rf_data  = bus.wb_data;
        end else if (head_grant) begin
            bus.rf_write = 1'b1;
        end else if (byp_grant) begin
            bus.rf_write = 1'b1;
            bus.rf_reg   = mu_req.dst;
            bus.rf_data  = mu_req.data;
        end
    end

    // ---- starvation stage: counts cycles the FIFO head has been passed over ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (empty || head_grant) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

    // ---- scoreboard stage: a new issue wins over a same-cycle retirement ----
    assign set_mask = reg_mask(bus.mu_issue_reg, bus.mu_issue);
    assign clr_mask = reg_mask(head_req.dst, head_grant) | reg_mask(mu_req.dst, byp_grant);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr_mask) | set_mask;
        end
    end

    assign bus.pending      = pending_q;
    assign bus.hazard_stall = reset && (pending_q[bus.dec_ra] |
                                        pending_q[bus.dec_rb] |
                                        pending_q[bus.dec_rd]);

    // Re-issuing to a register is only legal if its older result retires this cycle.
    a_issue_not_pending : assert property (@(posedge clk) disable iff (!reset)
        bus.mu_issue |-> !(pending_q[bus.mu_issue_reg] && !clr_mask[bus.mu_issue_reg]));

    a_mu_hold_stable : assert property (@(posedge clk) disable iff (!reset)
        (bus.mu_valid && !bus.mu_ready) |=> ($stable(bus.mu_reg) && $stable(bus.mu_data)));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; long-latency results are tracked in a
// scoreboard queue and matched against register-file writes as they appear.
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_write_arbiter_if bus();

    regfile_write_arbiter #(
        .FIFO_DEPTH (2),
        .STARVE_MAX (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [REG_W+DATA_W-1:0] sb_q [$];
    logic                    exp_wb = 1'b0;
    logic [REG_W+DATA_W-1:0] exp_wb_word = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        bus.wb_write     = 1'b0;
        bus.wb_reg       = '0;
        bus.wb_data      = '0;
        bus.mu_valid     = 1'b0;
        bus.mu_reg       = '0;
        bus.mu_data      = '0;
        bus.mu_issue     = 1'b0;
        bus.mu_issue_reg = '0;
        bus.dec_ra       = '0;
        bus.dec_rb       = '0;
        bus.dec_rd       = '0;
        exp_wb           = 1'b0;
    endtask

    task automatic drive_wb(input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
        bus.wb_write = 1'b1;
        bus.wb_reg   = r;
        bus.wb_data  = d;
        exp_wb       = 1'b1;
        exp_wb_word  = {r, d};
    endtask

    task automatic drive_mu(input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
        bus.mu_valid = 1'b1;
        bus.mu_reg   = r;
        bus.mu_data  = d;
        sb_q.push_back({r, d});
    endtask

    // Every register-file write is either the expected writeback or the oldest result.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.rf_write === 1'b1) begin
            if (exp_wb) begin
                check("wb_write_data", {13'd0, bus.rf_reg, bus.rf_data}, {13'd0, exp_wb_word});
            end else begin
                check("sb_nonempty", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    check("mu_write_data", {13'd0, bus.rf_reg, bus.rf_data},
                          {13'd0, sb_q.pop_front()});
                end
            end
        end
    end

    initial begin
        idle();
        reset        = 1'b0;
        bus.wb_write = 1'b1;
        bus.wb_reg   = 3'd1;
        bus.wb_data  = 16'hAAAA;
        bus.mu_valid = 1'b1;
        bus.mu_reg   = 3'd7;
        bus.mu_data  = 16'h7E7E;

        // Reset held for three edges with both requesters active.
        for (int i = 0; i < 3; i++) begin
            step();
            settle();
            check("rst_rf_write", bus.rf_write, 0);
            check("rst_mu_ready", bus.mu_ready, 0);
            check("rst_wb_stall", bus.wb_stall, 0);
            check("rst_pending", bus.pending, 0);
        end
        idle();
        reset = 1'b1;

        // Issue to r5, then its result returns; decode sees the hazard until retirement.
        step();
        idle();
        bus.mu_issue     = 1'b1;
        bus.mu_issue_reg = 3'd5;
        step();
        idle();
        bus.dec_ra = 3'd5;
        drive_mu(3'd5, 16'h1234);
        settle();
        check("t2_hazard_accept", bus.hazard_stall, 1);
        check("t2_pending_set", bus.pending, 8'h20);
        check("t2_mu_ready", bus.mu_ready, 1);
`ifdef WBARB_BYPASS_EN
        check("t2_bypass_write", bus.rf_write, 1);
`else
        check("t2_no_write_yet", bus.rf_write, 0);
`endif
        step();
        bus.mu_valid = 1'b0;
        settle();
`ifdef WBARB_BYPASS_EN
        check("t2_after_bypass_write", bus.rf_write, 0);
        check("t2_after_bypass_hazard", bus.hazard_stall, 0);
`else
        check("t2_fifo_write", bus.rf_write, 1);
        check("t2_fifo_reg", bus.rf_reg, 5);
        check("t2_hazard_until_edge", bus.hazard_stall, 1);
`endif
        step();
        settle();
        check("t2_hazard_clear", bus.hazard_stall, 0);
        check("t2_pending_clear", bus.pending, 0);

        // Continuous writeback starves one buffered result until it is forced.
        step();
        idle();
        drive_wb(3'd1, 16'hAAAA);
        drive_mu(3'd3, 16'h0333);
        settle();
        check("t3_accept_ready", bus.mu_ready, 1);
        check("t3_accept_stall", bus.wb_stall, 0);
        check("t3_accept_write", bus.rf_write, 1);
        for (int i = 1; i <= 4; i++) begin
            step();
            bus.mu_valid = 1'b0;
            settle();
            check("t3_denied_stall", bus.wb_stall, 0);
            check("t3_denied_write", bus.rf_write, 1);
        end
        step();
        exp_wb = 1'b0;
        settle();
        check("t3_force_stall", bus.wb_stall, 1);
        check("t3_force_reg", bus.rf_reg, 3);
        step();
        exp_wb = 1'b1;
        settle();
        check("t3_resume_stall", bus.wb_stall, 0);

        // Fill the FIFO; a third result waits stable until a pop frees a slot.
        step();
        drive_mu(3'd6, 16'h6666);
        settle();
        check("t4_ready_0", bus.mu_ready, 1);
        step();
        drive_mu(3'd7, 16'h7777);
        settle();
        check("t4_ready_1", bus.mu_ready, 1);
        step();
        drive_mu(3'd2, 16'h2222);
        settle();
        check("t4_full_ready_2", bus.mu_ready, 0);
        step();
        settle();
        check("t4_full_ready_3", bus.mu_ready, 0);
        check("t4_stall_3", bus.wb_stall, 0);
        step();
        settle();
        check("t4_full_ready_4", bus.mu_ready, 0);
        step();
        exp_wb = 1'b0;
        settle();
        check("t4_force_stall", bus.wb_stall, 1);
        check("t4_force_reg", bus.rf_reg, 6);
        check("t4_full_ready_5", bus.mu_ready, 0);
        step();
        exp_wb = 1'b1;
        settle();
        check("t4_ready_after_pop", bus.mu_ready, 1);
        check("t4_stall_6", bus.wb_stall, 0);
        step();
        idle();
        settle();
        check("t4_drain_reg7", bus.rf_reg, 7);
        step();
        settle();
        check("t4_drain_reg2", bus.rf_reg, 2);
        step();
        settle();
        check("t4_drained", bus.rf_write, 0);

        // Issue to r2 in the same cycle its older result retires: pending stays set.
        step();
        idle();
        bus.mu_issue     = 1'b1;
        bus.mu_issue_reg = 3'd2;
        settle();
        check("t5_pending_before", bus.pending, 0);
        step();
        idle();
        drive_wb(3'd1, 16'h5555);
        drive_mu(3'd2, 16'h0B0B);
        bus.dec_rb = 3'd2;
        settle();
        check("t5_pending_set", bus.pending, 8'h04);
        check("t5_hazard_rb", bus.hazard_stall, 1);
        step();
        idle();
        bus.mu_issue     = 1'b1;
        bus.mu_issue_reg = 3'd2;
        settle();
        check("t5_head_write", bus.rf_write, 1);
        check("t5_head_reg", bus.rf_reg, 2);
        step();
        idle();
        bus.dec_rd = 3'd2;
        settle();
        check("t5_set_wins", bus.pending, 8'h04);
        check("t5_hazard_rd", bus.hazard_stall, 1);
        step();
        idle();
        drive_mu(3'd2, 16'h0C0C);
        step();
        idle();
        step();
        settle();
        check("t5_pending_final", bus.pending, 0);

        // Result into an empty FIFO with no writeback competing.
        step();
        idle();
        drive_mu(3'd4, 16'h00FF);
        settle();
`ifdef WBARB_BYPASS_EN
        check("t6_same_cycle_write", bus.rf_write, 1);
        check("t6_same_cycle_reg", bus.rf_reg, 4);
`else
        check("t6_no_same_cycle_write", bus.rf_write, 0);
`endif
        step();
        idle();
        settle();
`ifdef WBARB_BYPASS_EN
        check("t6_next_cycle_idle", bus.rf_write, 0);
`else
        check("t6_next_cycle_write", bus.rf_write, 1);
        check("t6_next_cycle_reg", bus.rf_reg, 4);
`endif
        step();
        settle();
        check("sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
